fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding IMEM request at a time, feeding a DEPTH-entry in-order buffer.
// Latency: an acked word reaches the head the next cycle; head outputs come straight from registers.
// Backpressure: no request while the buffer is full; a taken branch flushes the buffer and redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        IMEM_Req,
    output logic [31:0] IMEM_Addr,
    input  logic        IMEM_Ack,
    input  logic [31:0] IMEM_Data,
    input  logic        BR_Taken,
    input  logic [31:0] BR_Target,
    output logic        Out_Valid,
    output logic [31:0] Out_Ins,
    output logic [31:0] Out_PC4,
    input  logic        In_Ready
);
    typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;

    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
    localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] ins_q [4];
    logic [31:0] pc4_q [4];
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q, count_after;
    logic        push, pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    // A redirect overrides both the incoming word and any pop in the same cycle.
    assign push        = (state_q == FETCH) && IMEM_Ack && !BR_Taken;
    assign pop         = Out_Valid && In_Ready && !BR_Taken;
    assign count_after = count_q + 3'(push) - 3'(pop);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (BR_Taken) begin
                    // Without a same-cycle ack the old request is still in flight.
                    state_d = IMEM_Ack ? FETCH : DRAIN;
                end else if (IMEM_Ack) begin
                    state_d = (count_after < DEPTH_C) ? FETCH : STALL;
                end
            end
            STALL: begin
                if (BR_Taken || (count_after < DEPTH_C)) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (IMEM_Ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        IMEM_Req  = 1'b0;
        IMEM_Addr = 32'h0;
        if (state_q == FETCH) begin
            IMEM_Req  = 1'b1;
            IMEM_Addr = pc_q;
        end
    end

    assign Out_Valid = (count_q != 3'd0);
    assign Out_Ins   = ins_q[rd_ptr_q];
    assign Out_PC4   = pc4_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pc_q     <= RESET_PC & 32'hFFFF_FFFC;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                ins_q[i] <= 32'h0;
                pc4_q[i] <= 32'h0;
            end
        end else if (BR_Taken) begin
            pc_q     <= BR_Target & 32'hFFFF_FFFC;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push) begin
                ins_q[wr_ptr_q] <= IMEM_Data;
                pc4_q[wr_ptr_q] <= pc_q + 32'd4;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
                pc_q            <= pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_after;
        end
    end
endmodule
